// File: rtl/ysyx_22040759_if_fq.sv
// Instruction-fetch stage with a multi-outstanding imem port and an in-order
// fetch queue of {inst, pc} feeding decode. A redirect flushes the queue and
// marks every in-flight response as stale so it is drained silently.
// Optional feature macro: YSYX_22040759_IF_PERF_EN adds the perf_fetch_cnt and
// perf_kill_cnt counter outputs.
module ysyx_22040759_if_fq #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h80000000,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redir_valid,
    input  logic [XLEN-1:0]      redir_pc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [XLEN-1:0]      imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [31:0]          imem_rsp_data,
    input  logic                 ds_allowin,
    output logic                 fs_to_ds_valid,
    output logic [32+XLEN-1:0]   fs_to_ds_bus
`ifdef YSYX_22040759_IF_PERF_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_kill_cnt
`endif
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] LP_DEPTH = (CW+1)'(FQ_DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [31:0]     r_inst [FQ_DEPTH];
    logic [XLEN-1:0] r_pc   [FQ_DEPTH];

    logic            w_empty;
    logic [CW:0]     w_credit;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redir_pc;

    // Credit = requests in flight plus entries queued; capping it at the
    // queue depth guarantees every fresh response has a free slot.
    assign w_empty        = (r_cnt == '0);
    assign w_credit       = {1'b0, r_outst} + {1'b0, r_cnt};
    assign imem_req_valid = ~rst & ~redir_valid & (w_credit < LP_DEPTH);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;
    assign w_redir_pc     = redir_pc & ~(XLEN'(3));

    // A response is kept only when it is not stale and no redirect is landing.
    assign w_push         = imem_rsp_valid & ~redir_valid & (r_drop == '0);

    assign fs_to_ds_valid = ~rst & ~w_empty & ~redir_valid;
    assign fs_to_ds_bus   = (rst | w_empty) ? '0 : {r_inst[r_rptr], r_pc[r_rptr]};
    assign w_pop          = fs_to_ds_valid & ds_allowin;

    // Control state: PCs, credit/drop counters and queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
            r_cnt      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_outst <= r_outst + CW'(w_req_fire) - CW'(imem_rsp_valid);
            if (redir_valid) begin
                r_fetch_pc <= w_redir_pc;
                r_rsp_pc   <= w_redir_pc;
                // Everything still in flight after this edge belongs to the old path.
                r_drop     <= r_outst - CW'(imem_rsp_valid);
                r_cnt      <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (imem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - 1'b1;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + XLEN'(4);
                    r_wptr   <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Queue payload storage; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[r_wptr] <= imem_rsp_data;
            r_pc[r_wptr]   <= r_rsp_pc;
        end
    end

`ifdef YSYX_22040759_IF_PERF_EN
    logic [31:0]   r_perf_fetch;
    logic [31:0]   r_perf_kill;
    logic [CW-1:0] w_kill_inc;

    // Killed work: flushed entries plus the response landing with a redirect,
    // or a stale response drained later.
    assign w_kill_inc = redir_valid ? (r_cnt + CW'(imem_rsp_valid))
                                    : CW'(imem_rsp_valid & (r_drop != '0));

    // Free-running performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_kill  <= '0;
        end else begin
            r_perf_fetch <= r_perf_fetch + 32'(w_pop);
            r_perf_kill  <= r_perf_kill + 32'(w_kill_inc);
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_kill_cnt  = r_perf_kill;
`endif

endmodule
